// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to DATA feed a small byte FIFO,
// an FSM serializes the bytes on tx, and STATUS reports FIFO/line state for polling.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  input  logic        Wr_en,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [31:0]   STAT_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t         state, state_next;
  logic [BW-1:0]  baud_cnt, baud_next;
  logic [2:0]     bit_idx, bit_next;
  logic [7:0]     shift, shift_next;
  logic           tx_next;

  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_next;
  logic           overflow;

  logic sel_data, sel_stat;
  logic full, empty;
  logic baud_done;
  logic wr_hit, push, pop, drop;
  logic unused_wr_bits;

  assign sel_data  = (address == BASE_ADDR);
  assign sel_stat  = (address == STAT_ADDR);
  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign busy      = (state != S_IDLE) || !empty;

  // Only the low byte of a store is transmitted.
  assign unused_wr_bits = ^wr_data[31:8];

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign wr_hit = Wr_en && sel_data;
  assign push   = wr_hit && (!full || pop);
  assign drop   = wr_hit && full && !pop;

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    tx_next    = tx;
    pop        = 1'b0;

    case (state)
      S_IDLE: begin
        tx_next   = 1'b1;
        baud_next = '0;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rd_ptr];
          state_next = S_START;
          tx_next    = 1'b0;
        end
      end

      S_START: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = S_DATA;
          tx_next    = shift[0];
        end else begin
          baud_next = baud_cnt + BAUD_ONE;
        end
      end

      S_DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = S_STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next   = bit_idx + 3'd1;
            shift_next = {1'b0, shift[7:1]};
            tx_next    = shift[1];
          end
        end else begin
          baud_next = baud_cnt + BAUD_ONE;
        end
      end

      S_STOP: begin
        if (baud_done) begin
          baud_next = '0;
          // Chain straight into the next start bit when more bytes are queued.
          if (!empty) begin
            pop        = 1'b1;
            shift_next = fifo_mem[rd_ptr];
            state_next = S_START;
            tx_next    = 1'b0;
          end else begin
            state_next = S_IDLE;
            tx_next    = 1'b1;
          end
        end else begin
          baud_next = baud_cnt + BAUD_ONE;
        end
      end

      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      tx       <= tx_next;
      count    <= count_next;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (Wr_en && sel_stat) begin
        overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // NOTE: the FIFO storage has no reset; entries are only read after being
  // written, and clearing the pointers and count empties the FIFO logically.
  always_ff @(posedge CLOCK_50) begin
    if (!rst && push) begin
      fifo_mem[wr_ptr] <= wr_data[7:0];
    end
  end

  always_comb begin
    rd_data = '0;
    if (sel_stat) begin
      rd_data = {24'h0, 4'(count), overflow, busy, empty, full};
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4:
// frame timing, back-to-back frames, overflow, full-plus-pop, reset abort, decode.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] STAT = BASE + 32'd4;
  localparam int          CPB  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic        Wr_en;
  logic [31:0] rd_data;
  logic        tx;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0;
  int lows;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .CLOCK_50(clk),
    .rst     (rst),
    .address (address),
    .wr_data (wr_data),
    .Wr_en   (Wr_en),
    .rd_data (rd_data),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address = a;
    wr_data = d;
    Wr_en   = 1'b1;
    tick();
    Wr_en   = 1'b0;
    address = 32'h0;
    wr_data = 32'h0;
  endtask

  task automatic rd_stat(input string tag, input logic [31:0] exp);
    address = STAT;
    #1;
    check(tag, rd_data, exp);
    address = 32'h0;
  endtask

  // Checks one full frame starting at the current cycle, leaving time one cycle past its end.
  task automatic check_frame(input string tag, input logic [7:0] d);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    for (int k = 0; k < 10 * CPB; k++) begin
      check($sformatf("%s_c%0d", tag, k), {31'b0, tx}, {31'b0, fr[k / CPB]});
      tick();
    end
  endtask

  initial begin
    rst     = 1'b1;
    address = 32'h0;
    wr_data = 32'h0;
    Wr_en   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rd_stat("rst_status", 32'h02);

    // Single byte 0x55: frame starts one cycle after the write, busy drops after 40 cycles
    wr(BASE, 32'h55);
    check("single_tx_at_write", {31'b0, tx}, 32'd1);
    check("single_busy_at_write", {31'b0, busy}, 32'd1);
    tick();
    check_frame("single", 8'h55);
    check("single_busy_end", {31'b0, busy}, 32'd0);
    check("single_tx_end", {31'b0, tx}, 32'd1);

    // Back-to-back writes: second frame follows the first stop bit with no gap
    wr(BASE, 32'hA0);
    wr(BASE, 32'h0F);
    check_frame("b2b_first", 8'hA0);
    check_frame("b2b_second", 8'h0F);
    check("b2b_busy_end", {31'b0, busy}, 32'd0);

    // Overflow: A on the line, B-E queued, F dropped
    wr(BASE, 32'h11);
    t0 = cyc;
    tick();
    tick();
    wr(BASE, 32'h22);
    wr(BASE, 32'h33);
    wr(BASE, 32'h44);
    wr(BASE, 32'h55);
    wr(BASE, 32'h66);
    rd_stat("ovf_status", 32'h4D);
    wr(STAT, 32'hDEAD_BEEF);
    rd_stat("ovf_cleared", 32'h45);

    // Full plus pop: write lands on the STOP->START pop edge of frame A
    while (cyc < t0 + 40) tick();
    wr(BASE, 32'h77);
    check("fullpop_tx_start", {31'b0, tx}, 32'd0);
    rd_stat("fullpop_status", 32'h45);

    // Reset mid-frame during data bit 3 of byte 0x22
    while (cyc < t0 + 49) tick();
    check("abort_bit1", {31'b0, tx}, 32'd1);
    while (cyc < t0 + 57) tick();
    check("abort_bit3", {31'b0, tx}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_tx", {31'b0, tx}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    rd_stat("abort_status", 32'h02);
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      if (tx !== 1'b1) lows++;
      tick();
    end
    check("abort_no_frame", lows, 0);

    // Decode: writes and reads elsewhere have no effect
    wr(BASE + 32'd8, 32'h41);
    address = BASE + 32'd12;
    #1;
    check("decode_rd_other", rd_data, 32'h0);
    address = BASE;
    #1;
    check("decode_rd_data", rd_data, 32'h0);
    address = 32'h0;
    rd_stat("decode_status", 32'h02);
    lows = 0;
    for (int k = 0; k < 50; k++) begin
      if (tx !== 1'b1) lows++;
      tick();
    end
    check("decode_no_frame", lows, 0);

    // Write in the same cycle as reset is ignored
    rst     = 1'b1;
    address = BASE;
    wr_data = 32'h99;
    Wr_en   = 1'b1;
    tick();
    rst     = 1'b0;
    Wr_en   = 1'b0;
    address = 32'h0;
    rd_stat("rstwr_status", 32'h02);
    tick();
    tick();
    check("rstwr_tx", {31'b0, tx}, 32'd1);
    check("rstwr_busy", {31'b0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
